spi_arbiter: RTL

Shares one `spi_controller` between `NUM_REQ` independent requesters, for example a sensor poller, a flash loader and a host bridge. Each requester posts a 64-bit frame plus per-transfer widths and mode. The arbiter grants one requester, kicks the controller, waits for completion and returns the received word with a one-cycle acknowledge. It also gates the controller's shared chip-select onto one of `NUM_REQ` per-device chip-selects.

---
 rtl/spi_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI controller among NUM_REQ requesters and steers its chip-select.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module spi_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [64*NUM_REQ-1:0]  REQ_DIN,
    input  logic [8*NUM_REQ-1:0]   REQ_MOSI_WIDTH,
    input  logic [8*NUM_REQ-1:0]   REQ_MISO_WIDTH,
    input  logic [2*NUM_REQ-1:0]   REQ_MODE,
    output logic [NUM_REQ-1:0]     ACK,
    output logic [63:0]            RDATA,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic                   SPI_KICK,
    input  logic                   SPI_BUSY,
    output logic [63:0]            SPI_DIN,
    output logic [7:0]             SPI_MOSI_WIDTH,
    output logic [7:0]             SPI_MISO_WIDTH,
    output logic                   SPI_CPOL,
    output logic                   SPI_CPHA,
    input  logic [63:0]            SPI_DOUT,
    input  logic                   SPI_CS,
    output logic [NUM_REQ-1:0]     CS_N
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, KICK, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               kick_q, kick_d;
    logic [63:0]        rdata_q, rdata_d;
    logic [63:0]        din_q, din_d;
    logic [7:0]         mosi_w_q, mosi_w_d;
    logic [7:0]         miso_w_q, miso_w_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;

    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic [7:0]         sel_mosi_w;
    logic [7:0]         sel_miso_w;
    logic [1:0]         sel_mode;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic [IW-1:0]      ptr_q, ptr_d;

    // Descending scan so the smallest offset from the pointer is the last writer.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (REQ[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_vld)
            ptr_d = IW'((int'(win_idx) + 1) % NUM_REQ);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (REQ[k]) begin
                win_vld = 1'b1;
                win_idx = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        sel_mosi_w = REQ_MOSI_WIDTH[8*win_idx +: 8];
        sel_miso_w = REQ_MISO_WIDTH[8*win_idx +: 8];
        sel_mode   = REQ_MODE[2*win_idx +: 2];
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = '0;
        kick_d   = kick_q;
        rdata_d  = rdata_q;
        din_d    = din_q;
        mosi_w_d = mosi_w_q;
        miso_w_d = miso_w_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    din_d            = REQ_DIN[64*win_idx +: 64];
                    mosi_w_d         = (sel_mosi_w == 8'd0) ? 8'd1 : sel_mosi_w;
                    miso_w_d         = (sel_miso_w == 8'd0) ? 8'd1 : sel_miso_w;
                    cpol_d           = sel_mode[1];
                    cpha_d           = sel_mode[0];
                    kick_d           = 1'b1;
                    state_d          = KICK;
                end
            end
            KICK: begin
                if (SPI_BUSY) begin
                    kick_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!SPI_BUSY) begin
                    rdata_d = SPI_DOUT;
                    ack_d   = grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            kick_q   <= 1'b0;
            rdata_q  <= '0;
            din_q    <= '0;
            mosi_w_q <= '0;
            miso_w_q <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            kick_q   <= kick_d;
            rdata_q  <= rdata_d;
            din_q    <= din_d;
            mosi_w_q <= mosi_w_d;
            miso_w_q <= miso_w_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
        end
    end

    assign ACK            = ack_q;
    assign RDATA          = rdata_q;
    assign GRANT          = grant_q;
    assign SPI_KICK       = kick_q;
    assign SPI_DIN        = din_q;
    assign SPI_MOSI_WIDTH = mosi_w_q;
    assign SPI_MISO_WIDTH = miso_w_q;
    assign SPI_CPOL       = cpol_q;
    assign SPI_CPHA       = cpha_q;
    // Only combinational path: the controller's CS reaches the granted device alone.
    assign CS_N           = {NUM_REQ{SPI_CS}} | ~grant_q;

endmodule
